// File: rtl/qkv_pkg.sv
// Shared types and helpers for the QKV sequence controller: default widths, FSM states,
// address-width and range helpers used by the controller and its row buffers.
package qkv_pkg;

  localparam int DATA_WIDTH_DEF  = 8;
  localparam int ACCUM_WIDTH_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_DONE = 3'd2,
    ST_CAPTURE   = 3'd3,
    ST_FINISH    = 3'd4
  } state_t;

  function automatic int addr_width(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

  function automatic logic in_range(input int addr, input int depth);
    return (addr < depth);
  endfunction

endpackage

// File: rtl/qkv_row_buffer.sv
// Single-write-port row store with a registered read port; out-of-range writes are dropped
// and out-of-range reads return zero.
module qkv_row_buffer
  import qkv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int AW    = addr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  // Sized to the full address space so any index is legal; only DEPTH rows are ever written.
  logic [WIDTH-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (wr_en && in_range(int'(wr_addr), DEPTH)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= in_range(int'(rd_addr), DEPTH) ? mem[rd_addr] : '0;
    end
  end

endmodule

// File: rtl/qkv_sequence_controller.sv
// Drives the projection unit once per buffered token and collects the Q/K/V rows into
// per-token buffers exposed through a registered read port.
module qkv_sequence_controller
  import qkv_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int ACCUM_WIDTH    = ACCUM_WIDTH_DEF,
  parameter int D_MODEL        = 3,
  parameter int D_K            = 2,
  parameter int D_V            = 2,
  parameter int SEQ_LEN        = 4,
  parameter int TIMEOUT_CYCLES = 255,
  localparam int AW            = addr_width(SEQ_LEN)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        x_wr_en,
  input  logic [AW-1:0]               x_wr_addr,
  input  logic [D_MODEL*DATA_WIDTH-1:0] x_wr_data,
  output logic                        proj_start,
  output logic [D_MODEL*DATA_WIDTH-1:0] proj_x,
  input  logic                        proj_busy,
  input  logic                        proj_done,
  input  logic [D_K*ACCUM_WIDTH-1:0]  proj_q,
  input  logic [D_K*ACCUM_WIDTH-1:0]  proj_k,
  input  logic [D_V*ACCUM_WIDTH-1:0]  proj_v,
  input  logic [AW-1:0]               rd_addr,
  output logic [D_K*ACCUM_WIDTH-1:0]  q_rd_data,
  output logic [D_K*ACCUM_WIDTH-1:0]  k_rd_data,
  output logic [D_V*ACCUM_WIDTH-1:0]  v_rd_data,
  output logic                        busy,
  output logic                        done,
  output logic                        error,
  output logic [AW-1:0]               token_idx
);

  localparam int XW = D_MODEL * DATA_WIDTH;
  localparam int QW = D_K * ACCUM_WIDTH;
  localparam int VW = D_V * ACCUM_WIDTH;
  localparam int CW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  state_t        state, state_nxt;
  logic [CW-1:0] tmo_cnt;
  logic          issue, capture, tok_wr, last_tok, timeout;

  assign last_tok = (token_idx == AW'(SEQ_LEN - 1));
  assign timeout  = (tmo_cnt == CW'(TIMEOUT_CYCLES));
  assign tok_wr   = x_wr_en && (state == ST_IDLE);

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    done      = 1'b0;
    issue     = 1'b0;
    capture   = 1'b0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        issue     = 1'b1;
        state_nxt = ST_WAIT_DONE;
      end
      // proj_busy is deliberately not consulted; completion is signalled by proj_done only
      ST_WAIT_DONE: begin
        if (proj_done)    state_nxt = ST_CAPTURE;
        else if (timeout) state_nxt = ST_IDLE;
      end
      ST_CAPTURE: begin
        capture   = 1'b1;
        state_nxt = last_tok ? ST_FINISH : ST_ISSUE;
      end
      ST_FINISH: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      token_idx  <= '0;
      tmo_cnt    <= '0;
      error      <= 1'b0;
      proj_start <= 1'b0;
    end else begin
      state      <= state_nxt;
      proj_start <= issue;
      case (state)
        ST_IDLE: begin
          if (start) begin
            error     <= 1'b0;
            token_idx <= '0;
          end
        end
        ST_ISSUE:     tmo_cnt <= '0;
        ST_WAIT_DONE: begin
          tmo_cnt <= tmo_cnt + CW'(1);
          if (!proj_done && timeout) error <= 1'b1;
        end
        ST_CAPTURE:   if (!last_tok) token_idx <= token_idx + AW'(1);
        default: ;
      endcase
    end
  end

  // The token buffer read fires in ISSUE so proj_x and the proj_start pulse appear together
  // and proj_x then holds until the next ISSUE.
  qkv_row_buffer #(.WIDTH(XW), .DEPTH(SEQ_LEN), .AW(AW)) u_tok_buf (
    .clk(clk), .rst_n(rst_n),
    .wr_en(tok_wr), .wr_addr(x_wr_addr), .wr_data(x_wr_data),
    .rd_en(issue), .rd_addr(token_idx), .rd_data(proj_x)
  );

  qkv_row_buffer #(.WIDTH(QW), .DEPTH(SEQ_LEN), .AW(AW)) u_q_buf (
    .clk(clk), .rst_n(rst_n),
    .wr_en(capture), .wr_addr(token_idx), .wr_data(proj_q),
    .rd_en(1'b1), .rd_addr(rd_addr), .rd_data(q_rd_data)
  );

  qkv_row_buffer #(.WIDTH(QW), .DEPTH(SEQ_LEN), .AW(AW)) u_k_buf (
    .clk(clk), .rst_n(rst_n),
    .wr_en(capture), .wr_addr(token_idx), .wr_data(proj_k),
    .rd_en(1'b1), .rd_addr(rd_addr), .rd_data(k_rd_data)
  );

  qkv_row_buffer #(.WIDTH(VW), .DEPTH(SEQ_LEN), .AW(AW)) u_v_buf (
    .clk(clk), .rst_n(rst_n),
    .wr_en(capture), .wr_addr(token_idx), .wr_data(proj_v),
    .rd_en(1'b1), .rd_addr(rd_addr), .rd_data(v_rd_data)
  );

endmodule

// File: tb/tb_qkv_sequence_controller.sv
// Bench for qkv_sequence_controller: a one-token and a four-token instance, each driven by a
// behavioural projection unit with the Test Case 1 weights; read rows go through a scoreboard.
module tb_qkv_sequence_controller;

  localparam int WQ[3][2] = '{'{1, 2}, '{3, 1}, '{2, 3}};
  localparam int WK[3][2] = '{'{2, 1}, '{1, 3}, '{3, 2}};
  localparam int WV[3][2] = '{'{1, 3}, '{2, 2}, '{3, 1}};
  localparam int BQ = 1, BK = 2, BV = 3;

  logic clk_tb = 1'b0;
  always #5 clk_tb = ~clk_tb;

  int errors = 0;
  int checks = 0;

  typedef struct { logic [31:0] q; logic [31:0] k; logic [31:0] v; } row_t;
  row_t sb1[$];
  row_t sb4[$];

  // one-token instance
  logic        rst_n1, s1_start, s1_wr_en, s1_proj_start, s1_proj_busy, s1_proj_done;
  logic        s1_busy, s1_done, s1_error, s1_wr_addr, s1_rd_addr, s1_tok;
  logic [23:0] s1_wr_data, s1_proj_x;
  logic [31:0] s1_proj_q, s1_proj_k, s1_proj_v, s1_q_rd, s1_k_rd, s1_v_rd;

  // four-token instance
  logic        rst_n4, s4_start, s4_wr_en, s4_proj_start, s4_proj_busy, s4_proj_done;
  logic        s4_busy, s4_done, s4_error;
  logic [1:0]  s4_wr_addr, s4_rd_addr, s4_tok;
  logic [23:0] s4_wr_data, s4_proj_x;
  logic [31:0] s4_proj_q, s4_proj_k, s4_proj_v, s4_q_rd, s4_k_rd, s4_v_rd;

  qkv_sequence_controller #(.SEQ_LEN(1)) u_dut1 (
    .clk(clk_tb), .rst_n(rst_n1), .start(s1_start), .x_wr_en(s1_wr_en),
    .x_wr_addr(s1_wr_addr), .x_wr_data(s1_wr_data), .proj_start(s1_proj_start),
    .proj_x(s1_proj_x), .proj_busy(s1_proj_busy), .proj_done(s1_proj_done),
    .proj_q(s1_proj_q), .proj_k(s1_proj_k), .proj_v(s1_proj_v), .rd_addr(s1_rd_addr),
    .q_rd_data(s1_q_rd), .k_rd_data(s1_k_rd), .v_rd_data(s1_v_rd), .busy(s1_busy),
    .done(s1_done), .error(s1_error), .token_idx(s1_tok)
  );

  qkv_sequence_controller #(.SEQ_LEN(4)) u_dut4 (
    .clk(clk_tb), .rst_n(rst_n4), .start(s4_start), .x_wr_en(s4_wr_en),
    .x_wr_addr(s4_wr_addr), .x_wr_data(s4_wr_data), .proj_start(s4_proj_start),
    .proj_x(s4_proj_x), .proj_busy(s4_proj_busy), .proj_done(s4_proj_done),
    .proj_q(s4_proj_q), .proj_k(s4_proj_k), .proj_v(s4_proj_v), .rd_addr(s4_rd_addr),
    .q_rd_data(s4_q_rd), .k_rd_data(s4_k_rd), .v_rd_data(s4_v_rd), .busy(s4_busy),
    .done(s4_done), .error(s4_error), .token_idx(s4_tok)
  );

  function automatic logic [95:0] proj_fn(input logic [23:0] x);
    int q[2], k[2], v[2];
    int xi;
    for (int j = 0; j < 2; j++) begin
      q[j] = BQ; k[j] = BK; v[j] = BV;
    end
    for (int i = 0; i < 3; i++) begin
      xi = int'(signed'(x[i*8 +: 8]));
      for (int j = 0; j < 2; j++) begin
        q[j] += xi * WQ[i][j];
        k[j] += xi * WK[i][j];
        v[j] += xi * WV[i][j];
      end
    end
    return {16'(v[1]), 16'(v[0]), 16'(k[1]), 16'(k[0]), 16'(q[1]), 16'(q[0])};
  endfunction

  function automatic logic [31:0] p2(input int a0, input int a1);
    return {16'(a1), 16'(a0)};
  endfunction

  function automatic logic [23:0] p3(input int a0, input int a1, input int a2);
    return {8'(a2), 8'(a1), 8'(a0)};
  endfunction

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // behavioural projection units: done (with results) one cycle after op_start is seen
  logic        m1_en = 1'b1, m1_pend = 1'b0, m4_en = 1'b1, m4_pend = 1'b0;
  logic [23:0] m1_x, m4_x;

  always @(posedge clk_tb) begin
    s1_proj_done <= 1'b0;
    if (m1_pend) begin
      {s1_proj_v, s1_proj_k, s1_proj_q} <= proj_fn(m1_x);
      s1_proj_done <= 1'b1;
      s1_proj_busy <= 1'b0;
      m1_pend      <= 1'b0;
    end
    if (s1_proj_start && m1_en) begin
      m1_pend <= 1'b1; m1_x <= s1_proj_x; s1_proj_busy <= 1'b1;
    end
  end

  always @(posedge clk_tb) begin
    s4_proj_done <= 1'b0;
    if (m4_pend) begin
      {s4_proj_v, s4_proj_k, s4_proj_q} <= proj_fn(m4_x);
      s4_proj_done <= 1'b1;
      s4_proj_busy <= 1'b0;
      m4_pend      <= 1'b0;
    end
    if (s4_proj_start && m4_en) begin
      m4_pend <= 1'b1; m4_x <= s4_proj_x; s4_proj_busy <= 1'b1;
    end
  end

  // read-port scoreboard monitor
  logic rd_chk1 = 1'b0, rd_chk4 = 1'b0, rd_vld1 = 1'b0, rd_vld4 = 1'b0;
  always @(posedge clk_tb) begin
    rd_vld1 <= rd_chk1;
    rd_vld4 <= rd_chk4;
  end

  always @(negedge clk_tb) begin
    row_t e;
    if (rd_vld1) begin
      if (sb1.size() == 0) chk("sb1_underflow", 1, 0);
      else begin
        e = sb1.pop_front();
        chk("rd1_row", {s1_q_rd, s1_k_rd, s1_v_rd}, {e.q, e.k, e.v});
      end
    end
    if (rd_vld4) begin
      if (sb4.size() == 0) chk("sb4_underflow", 1, 0);
      else begin
        e = sb4.pop_front();
        chk("rd4_row", {s4_q_rd, s4_k_rd, s4_v_rd}, {e.q, e.k, e.v});
      end
    end
  end

  task automatic rd1(input logic a, input logic [31:0] q, input logic [31:0] k, input logic [31:0] v);
    @(negedge clk_tb);
    s1_rd_addr = a; rd_chk1 = 1'b1;
    sb1.push_back('{q: q, k: k, v: v});
  endtask

  task automatic rd4(input logic [1:0] a, input logic [31:0] q, input logic [31:0] k, input logic [31:0] v);
    @(negedge clk_tb);
    s4_rd_addr = a; rd_chk4 = 1'b1;
    sb4.push_back('{q: q, k: k, v: v});
  endtask

  task automatic rd_end();
    @(negedge clk_tb);
    rd_chk1 = 1'b0; rd_chk4 = 1'b0;
    repeat (2) @(negedge clk_tb);
  endtask

  task automatic wr4(input logic [1:0] a, input logic [23:0] d);
    @(negedge clk_tb);
    s4_wr_en = 1'b1; s4_wr_addr = a; s4_wr_data = d;
    @(negedge clk_tb);
    s4_wr_en = 1'b0;
  endtask

  task automatic sweep4();
    rd4(2'd0, p2(14, 14),   p2(15, 15),   p2(17, 13));
    rd4(2'd1, p2(1, 1),     p2(2, 2),     p2(3, 3));
    rd4(2'd2, p2(-12, -12), p2(-11, -11), p2(-11, -7));
    rd4(2'd3, p2(2, 3),     p2(4, 3),     p2(4, 6));
    rd_end();
  endtask

  task automatic run4(input bit interfere);
    int st, dn;
    @(negedge clk_tb); s4_start = 1'b1;
    @(negedge clk_tb); s4_start = 1'b0;
    chk("err_cleared_on_start", s4_error, 0);
    chk("busy_after_start", s4_busy, 1);
    st = 0; dn = 0;
    for (int c = 0; c < 200 && dn == 0; c++) begin
      if (interfere && c == 5) begin
        s4_start = 1'b1; s4_wr_en = 1'b1; s4_wr_addr = 2'd3; s4_wr_data = p3(9, 9, 9);
      end
      if (interfere && c == 6) begin
        s4_start = 1'b0; s4_wr_en = 1'b0;
      end
      @(negedge clk_tb);
      st += int'(s4_proj_start);
      dn += int'(s4_done);
    end
    chk("run4_proj_starts", st, 4);
    chk("run4_done_pulses", dn, 1);
    @(negedge clk_tb);
    chk("run4_busy_end", s4_busy, 0);
    chk("run4_error_end", s4_error, 0);
    repeat (3) @(negedge clk_tb);
    chk("run4_no_second_run", s4_busy, 0);
  endtask

  initial begin
    int st, dn, seen;
    rst_n1 = 1'b0; rst_n4 = 1'b0;
    s1_start = 1'b0; s1_wr_en = 1'b0; s1_wr_addr = 1'b0; s1_wr_data = '0; s1_rd_addr = 1'b0;
    s4_start = 1'b0; s4_wr_en = 1'b0; s4_wr_addr = '0;   s4_wr_data = '0; s4_rd_addr = '0;
    repeat (2) @(negedge clk_tb);
    chk("rst_busy",       s4_busy, 0);
    chk("rst_done",       s4_done, 0);
    chk("rst_error",      s4_error, 0);
    chk("rst_proj_start", s4_proj_start, 0);
    chk("rst_token_idx",  s4_tok, 0);
    chk("rst_proj_x",     s4_proj_x, 0);
    chk("rst_q_rd",       s4_q_rd, 0);
    chk("rst_busy1",      s1_busy, 0);
    rst_n1 = 1'b1; rst_n4 = 1'b1;

    // single token, row written in the same cycle as start
    @(negedge clk_tb);
    s1_wr_en = 1'b1; s1_wr_addr = 1'b0; s1_wr_data = p3(1, 2, 3); s1_start = 1'b1;
    @(negedge clk_tb);
    s1_wr_en = 1'b0; s1_start = 1'b0;
    st = 0; dn = 0;
    for (int c = 0; c < 50 && dn == 0; c++) begin
      @(negedge clk_tb);
      if (s1_proj_start) chk("run1_proj_x", s1_proj_x, p3(1, 2, 3));
      st += int'(s1_proj_start);
      dn += int'(s1_done);
    end
    chk("run1_proj_starts", st, 1);
    chk("run1_done_pulses", dn, 1);
    @(negedge clk_tb);
    chk("run1_busy_end", s1_busy, 0);
    chk("run1_error", s1_error, 0);
    rd1(1'b0, p2(14, 14), p2(15, 15), p2(17, 13));
    rd1(1'b1, 32'd0, 32'd0, 32'd0);
    rd_end();

    // four tokens, then sweep the read port
    wr4(2'd0, p3(1, 2, 3));
    wr4(2'd1, p3(0, 0, 0));
    wr4(2'd2, p3(-1, -2, -3));
    wr4(2'd3, p3(1, 0, 0));
    run4(1'b0);
    sweep4();

    // projection never completes: timeout
    m4_en = 1'b0;
    @(negedge clk_tb); s4_start = 1'b1;
    @(negedge clk_tb); s4_start = 1'b0;
    st = 0; dn = 0; seen = -1;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk_tb);
      st += int'(s4_proj_start);
      dn += int'(s4_done);
      if (s4_error) begin
        seen = c;
        break;
      end
    end
    chk("tmo_error_cycle", seen, 256);
    chk("tmo_busy", s4_busy, 0);
    chk("tmo_no_done", dn, 0);
    chk("tmo_proj_starts", st, 1);
    repeat (3) @(negedge clk_tb);
    chk("tmo_error_sticky", s4_error, 1);
    m4_en = 1'b1;

    // start/x_wr_en mid-run are ignored; error cleared by the new start
    run4(1'b1);
    sweep4();

    // reset while waiting on token 2
    @(negedge clk_tb); s4_start = 1'b1;
    @(negedge clk_tb); s4_start = 1'b0;
    st = 0;
    for (int c = 0; c < 100 && st < 3; c++) begin
      @(negedge clk_tb);
      st += int'(s4_proj_start);
    end
    chk("rstrun_reached_tok2", st, 3);
    chk("rstrun_token_idx", s4_tok, 2);
    rst_n4 = 1'b0;
    @(negedge clk_tb);
    chk("rstrun_busy", s4_busy, 0);
    chk("rstrun_proj_start", s4_proj_start, 0);
    chk("rstrun_token_idx0", s4_tok, 0);
    rst_n4 = 1'b1;
    dn = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_tb);
      dn += int'(s4_done);
    end
    chk("rstrun_no_done", dn, 0);
    chk("rstrun_idle", s4_busy, 0);

    chk("sb_drained", sb1.size() + sb4.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
